ins_mem: RTL and testbench
==========================

// Module: ins_mem
// PURPOSE
//  - Single-port instruction memory for the microprocessor: 2**PC_BITS words x 16 bits.
//  - Addressed by the program counter; loaded by the host/loader through the same port.
//  - Read data is registered and feeds the fetch/decode stage.
// PARAMETERS
//  - PC_BITS  6  address width; depth = 2**PC_BITS words (64 by default)
// PORTS
//  - clka            in   1        sole clock; all state updates on its rising edge
//  - reset           in   1        synchronous, active-high reset
//  - we_insmem       in   1        write enable: 1 = write instruction_in to mem[pc]
//  - pc              in   PC_BITS  word address (program counter)
//  - instruction_in  in   16       write data
//  - instruction_out out  16       registered read data
// BEHAVIOUR
//  - One clock (clka); reset is synchronous and active-high. There is no second clock.
//  - Storage: reg array [0:2**PC_BITS-1] of 16 bits. Addressing is byte-free word addressing.
//    All pc values are valid; there is no out-of-range case.
//  - Reset (reset=1 at a clka edge):
//    - instruction_out <= 16'h0000.
//    - Memory contents are preserved.
//    - Writes are suppressed while reset=1; reset has priority over we_insmem.
//  - Write (reset=0, we_insmem=1): mem[pc] <= instruction_in at the rising edge.
//  - Read, every non-reset edge: instruction_out <= mem[pc]. Latency is 1 clka cycle;
//    the output holds between edges.
//  - Read-during-write (same pc, same edge) is write-first: instruction_out takes
//    instruction_in on that edge.
//  - we_insmem=0: instruction_in is ignored completely; memory is unchanged.
//  - No handshake and no stall. Back-to-back accesses to any addresses are allowed
//    on every cycle.
//  - Output after power-up and before the first reset or read: 0 if the optional
//    feature is enabled, otherwise unspecified.
// CONFIGURATION
//  - INSMEM_ZERO_INIT_EN defined:
//    - Every memory word and instruction_out are initialised to 16'h0000 at time 0
//      (simulation initial / FPGA bitstream init).
//    - An unwritten address reads 0.
//  - INSMEM_ZERO_INIT_EN undefined:
//    - No initialisation. An unwritten address reads X in simulation.
//    - Software must load every word before executing it.
// TESTING
//  - Reset: reset=1 for 1 edge -> instruction_out=0x0000. Then write 0x1234@pc=5,
//    assert reset, release, read pc=5 -> 0x1234 (contents survive reset).
//  - Single write then read: we=1,pc=0,in=1 -> out=0x0001 on the same edge (write-first).
//    Then we=0,pc=0,in=0 -> out stays 0x0001.
//  - Fill: we=1, for i=0,2,..,62: pc=i,in=i, two edges each -> out=i after each edge.
//  - Read-back: we=0, in=65, for i=0,2,..,62: pc=i -> out=i. Value 65 never appears.
//  - Boundary/reset priority: write 0xBEEF@pc=63 -> read pc=63 gives 0xBEEF.
//    Then reset=1,we=1,pc=63,in=0x0000 -> out=0. Release reset, read pc=63 -> 0xBEEF.
//  - Zero-init (macro on): read pc=1 before any write -> 0x0000.
//    With the macro off, the same read returns X.

Source files
------------

// File: rtl/ins_mem_if.sv
// Instruction memory bus: program counter address, write strobe/data from the
// loader, and registered instruction read data back to fetch/decode.
interface ins_mem_if #(
    parameter int PC_BITS = 6
);
    logic               we_insmem;
    logic [PC_BITS-1:0] pc;
    logic [15:0]        instruction_in;
    logic [15:0]        instruction_out;

    // Processor/loader side: drives address, write strobe and data.
    modport master (
        output we_insmem,
        output pc,
        output instruction_in,
        input  instruction_out
    );

    // Memory side: consumes the address/write strobe and returns read data.
    modport slave (
        input  we_insmem,
        input  pc,
        input  instruction_in,
        output instruction_out
    );
endinterface

// File: rtl/ins_mem.sv
// Single-port instruction memory, 2**PC_BITS words of 16 bits, one clka-cycle
// registered read latency with write-first behaviour on a same-address write.
// Optional build macro INSMEM_ZERO_INIT_EN: when defined, every memory word and
// the read register start at 16'h0000; otherwise they start uninitialised.
module ins_mem #(
    parameter int PC_BITS = 6
) (
    input  logic    clka,
    input  logic    reset,
    ins_mem_if.slave bus
);
    localparam int DEPTH = 2 ** PC_BITS;

`ifdef INSMEM_ZERO_INIT_EN
    logic [15:0] mem [0:DEPTH-1] = '{default: 16'h0000};
    logic [15:0] rd_data_p1      = 16'h0000;
`else
    logic [15:0] mem [0:DEPTH-1];
    logic [15:0] rd_data_p1;
`endif

    logic wr_en_p0;

    // Reset blocks writes so the loaded program survives a processor reset.
    assign wr_en_p0 = bus.we_insmem & ~reset;

    // Storage array write port; no reset so the array maps onto block RAM.
    always_ff @(posedge clka) begin
        if (wr_en_p0) begin
            mem[bus.pc] <= bus.instruction_in;
        end
    end

    // Registered read port: write data is forwarded on a write so the fetched
    // word always reflects the value stored at this edge.
    always_ff @(posedge clka) begin
        if (reset) begin
            rd_data_p1 <= 16'h0000;
        end else if (bus.we_insmem) begin
            rd_data_p1 <= bus.instruction_in;
        end else begin
            rd_data_p1 <= mem[bus.pc];
        end
    end

    // ---- stage p1: registered instruction to fetch/decode ----
    assign bus.instruction_out = rd_data_p1;
endmodule

// File: tb/tb_ins_mem.sv
// Scoreboard bench for ins_mem: the stimulus task pushes the hand-computed
// expected read word for each edge; a negedge monitor pops and compares.
module tb_ins_mem;
    localparam int PC_BITS = 6;

    typedef struct {
        logic [15:0] exp;
        string       name;
    } sb_entry_t;

    logic clka  = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    sb_entry_t sb [$];

    ins_mem_if #(.PC_BITS(PC_BITS)) bus ();

    ins_mem #(.PC_BITS(PC_BITS)) dut (
        .clka  (clka),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clka = ~clka;

    // Drive one edge's inputs at the negedge, then queue the expected output.
    task automatic step(input logic rst, input logic we, input logic [PC_BITS-1:0] addr,
                        input logic [15:0] din, input logic [15:0] exp, input string name);
        sb_entry_t e;
        @(negedge clka);
        reset              = rst;
        bus.we_insmem      = we;
        bus.pc             = addr;
        bus.instruction_in = din;
        @(posedge clka);
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: compare the settled output against the oldest expectation.
    always @(negedge clka) begin
        if (sb.size() > 0) begin
            sb_entry_t e;
            e = sb.pop_front();
            checks = checks + 1;
            if (bus.instruction_out !== e.exp) begin
                failures = failures + 1;
                $display("FAIL %s: got %h expected %h", e.name, bus.instruction_out, e.exp);
            end
        end
    end

    initial begin
        logic [15:0] v;
        bus.we_insmem      = 1'b0;
        bus.pc             = '0;
        bus.instruction_in = 16'h0000;

        // Reset clears the output register.
        step(1'b1, 1'b0, 6'd0, 16'h0000, 16'h0000, "reset_out");

`ifdef INSMEM_ZERO_INIT_EN
        // Unwritten word reads zero.
        step(1'b0, 1'b0, 6'd1, 16'h0000, 16'h0000, "zero_init_pc1");
`endif

        // Contents survive reset.
        step(1'b0, 1'b1, 6'd5, 16'h1234, 16'h1234, "wr_pc5_wf");
        step(1'b1, 1'b0, 6'd5, 16'h0000, 16'h0000, "reset_again");
        step(1'b0, 1'b0, 6'd5, 16'h0000, 16'h1234, "pc5_after_reset");

        // Write-first then hold with we=0.
        step(1'b0, 1'b1, 6'd0, 16'h0001, 16'h0001, "wr_pc0_wf");
        step(1'b0, 1'b0, 6'd0, 16'h0000, 16'h0001, "rd_pc0_hold");

        // Fill even addresses, two edges each.
        for (int i = 0; i < 64; i += 2) begin
            v = 16'(i);
            step(1'b0, 1'b1, 6'(i), v, v, "fill_a");
            step(1'b0, 1'b1, 6'(i), v, v, "fill_b");
        end

        // Read back with junk on instruction_in; 65 must never appear.
        for (int i = 0; i < 64; i += 2) begin
            v = 16'(i);
            step(1'b0, 1'b0, 6'(i), 16'd65, v, "readback");
        end
        step(1'b0, 1'b0, 6'd5, 16'd65, 16'h1234, "pc5_untouched");

        // Top address and reset priority over a write.
        step(1'b0, 1'b1, 6'd63, 16'hBEEF, 16'hBEEF, "wr_pc63");
        step(1'b0, 1'b0, 6'd63, 16'h0000, 16'hBEEF, "rd_pc63");
        step(1'b1, 1'b1, 6'd63, 16'h0000, 16'h0000, "reset_with_we");
        step(1'b0, 1'b0, 6'd63, 16'h0000, 16'hBEEF, "pc63_kept");
        step(1'b0, 1'b0, 6'd62, 16'hFFFF, 16'd62, "rd_pc62");

        @(negedge clka);
        #1;
        if (sb.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
